// File: rtl/ws2812b_rx_decoder.sv
`default_nettype none
// ============================================================================
// Module : ws2812b_rx_decoder
// Desc   : WS2812B NRZ receiver - pulse-width bit decode, 24-bit GRB words on
//          a valid/ready port, reset-gap frame detection with word count.
// Rev    : 1.0
// ============================================================================
module ws2812b_rx_decoder #(
   parameter int THRESH       = 38,
   parameter int MIN_HIGH     = 8,
   parameter int MAX_HIGH     = 96,
   parameter int RESET_CYCLES = 3200
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        din,
   output logic [23:0] data_out,
   output logic        data_valid,
   input  logic        data_ready,
   output logic        frame_end,
   output logic [7:0]  frame_words,
   output logic        bit_error,
   output logic        overrun,
   input  logic        clear_err
);

   localparam int CW = $clog2(RESET_CYCLES + 1);
   localparam logic [CW-1:0] c_thresh   = CW'(THRESH);
   localparam logic [CW-1:0] c_min_high = CW'(MIN_HIGH);
   localparam logic [CW-1:0] c_max_high = CW'(MAX_HIGH);
   localparam logic [CW-1:0] c_reset    = CW'(RESET_CYCLES);
   localparam logic [CW-1:0] c_cnt_max  = '1;

   typedef enum logic [2:0] {
      S_SYNC  = 3'd0,
      S_IDLE  = 3'd1,
      S_HIGH  = 3'd2,
      S_LOW   = 3'd3,
      S_ERROR = 3'd4
   } state_t;

   state_t        state_q, state_d;
   logic          din_m_q, din_m_d, din_s_q, din_s_d, din_p_q, din_p_d;
   logic [CW-1:0] hcnt_q, hcnt_d, lcnt_q, lcnt_d;
   logic [4:0]    bitcnt_q, bitcnt_d;
   logic [22:0]   shift_q, shift_d;
   logic [7:0]    wcnt_q, wcnt_d;
   logic          done_q, done_d;
   logic [23:0]   word_q, word_d;
   logic [23:0]   data_out_q, data_out_d;
   logic          data_valid_q, data_valid_d;
   logic          frame_end_q, frame_end_d;
   logic [7:0]    frame_words_q, frame_words_d;
   logic          bit_error_q, bit_error_d;
   logic          overrun_q, overrun_d;

   logic          rise, new_bit, err_set, ovr_set;
   logic [CW-1:0] hcnt_inc, lcnt_inc;

   always_comb begin
      din_m_d       = din;
      din_s_d       = din_m_q;
      din_p_d       = din_s_q;
      rise          = din_s_q & ~din_p_q;
      hcnt_inc      = (hcnt_q == c_cnt_max) ? hcnt_q : hcnt_q + CW'(1);
      lcnt_inc      = (lcnt_q == c_cnt_max) ? lcnt_q : lcnt_q + CW'(1);
      new_bit       = (hcnt_q >= c_thresh);

      state_d       = state_q;
      hcnt_d        = hcnt_q;
      lcnt_d        = lcnt_q;
      bitcnt_d      = bitcnt_q;
      shift_d       = shift_q;
      wcnt_d        = wcnt_q;
      done_d        = 1'b0;
      word_d        = word_q;
      frame_end_d   = 1'b0;
      frame_words_d = frame_words_q;
      err_set       = 1'b0;

      case (state_q)
         S_SYNC, S_ERROR: begin
            // Any high restarts the wait: only an unbroken low gap re-arms decoding.
            if (din_s_q) begin
               lcnt_d = '0;
            end else if (lcnt_q == c_reset) begin
               state_d = S_IDLE;
               lcnt_d  = '0;
            end else begin
               lcnt_d = lcnt_inc;
            end
         end
         S_IDLE: begin
            if (rise) begin
               state_d = S_HIGH;
               hcnt_d  = CW'(1);
            end
         end
         S_HIGH: begin
            if (din_s_q) begin
               if (hcnt_inc >= c_max_high) begin
                  state_d  = S_ERROR;
                  err_set  = 1'b1;
                  bitcnt_d = '0;
                  wcnt_d   = '0;
                  shift_d  = '0;
                  lcnt_d   = '0;
               end else begin
                  hcnt_d = hcnt_inc;
               end
            end else if (hcnt_q < c_min_high) begin
               state_d  = S_ERROR;
               err_set  = 1'b1;
               bitcnt_d = '0;
               wcnt_d   = '0;
               shift_d  = '0;
               lcnt_d   = '0;
            end else begin
               state_d = S_LOW;
               lcnt_d  = CW'(1);
               if (bitcnt_q == 5'd23) begin
                  done_d   = 1'b1;
                  word_d   = {shift_q, new_bit};
                  bitcnt_d = '0;
                  shift_d  = '0;
                  wcnt_d   = (wcnt_q == 8'hFF) ? wcnt_q : wcnt_q + 8'd1;
               end else begin
                  bitcnt_d = bitcnt_q + 5'd1;
                  shift_d  = {shift_q[21:0], new_bit};
               end
            end
         end
         S_LOW: begin
            if (rise) begin
               state_d = S_HIGH;
               hcnt_d  = CW'(1);
            end else if (lcnt_q == c_reset) begin
               state_d       = S_IDLE;
               frame_end_d   = 1'b1;
               frame_words_d = wcnt_q;
               wcnt_d        = '0;
               bitcnt_d      = '0;
               shift_d       = '0;
               err_set       = (bitcnt_q != 5'd0);
            end else begin
               lcnt_d = lcnt_inc;
            end
         end
         default: state_d = S_SYNC;
      endcase

      // Output stage: a finished word may reuse the slot being freed this cycle.
      data_out_d   = data_out_q;
      data_valid_d = data_valid_q;
      ovr_set      = 1'b0;
      if (data_valid_q && data_ready) begin
         data_valid_d = 1'b0;
      end
      if (done_q) begin
         if (!data_valid_q || data_ready) begin
            data_out_d   = word_q;
            data_valid_d = 1'b1;
         end else begin
            ovr_set = 1'b1;
         end
      end

      bit_error_d = (bit_error_q & ~clear_err) | err_set;
      overrun_d   = (overrun_q & ~clear_err) | ovr_set;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= S_SYNC;
         din_m_q       <= 1'b0;
         din_s_q       <= 1'b0;
         din_p_q       <= 1'b0;
         hcnt_q        <= '0;
         lcnt_q        <= '0;
         bitcnt_q      <= '0;
         shift_q       <= '0;
         wcnt_q        <= '0;
         done_q        <= 1'b0;
         word_q        <= '0;
         data_out_q    <= '0;
         data_valid_q  <= 1'b0;
         frame_end_q   <= 1'b0;
         frame_words_q <= '0;
         bit_error_q   <= 1'b0;
         overrun_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         din_m_q       <= din_m_d;
         din_s_q       <= din_s_d;
         din_p_q       <= din_p_d;
         hcnt_q        <= hcnt_d;
         lcnt_q        <= lcnt_d;
         bitcnt_q      <= bitcnt_d;
         shift_q       <= shift_d;
         wcnt_q        <= wcnt_d;
         done_q        <= done_d;
         word_q        <= word_d;
         data_out_q    <= data_out_d;
         data_valid_q  <= data_valid_d;
         frame_end_q   <= frame_end_d;
         frame_words_q <= frame_words_d;
         bit_error_q   <= bit_error_d;
         overrun_q     <= overrun_d;
      end
   end

   assign data_out    = data_out_q;
   assign data_valid  = data_valid_q;
   assign frame_end   = frame_end_q;
   assign frame_words = frame_words_q;
   assign bit_error   = bit_error_q;
   assign overrun     = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_ws2812b_rx_decoder.sv
`default_nettype none
// ============================================================================
// Module : tb_ws2812b_rx_decoder
// Desc   : Pulse-train stimulus for ws2812b_rx_decoder, checked against a
//          word/frame-level decode model and handshake scoreboard.
// Rev    : 1.0
// ============================================================================
module tb_ws2812b_rx_decoder;

   localparam int THRESH       = 38;
   localparam int MIN_HIGH     = 8;
   localparam int MAX_HIGH     = 96;
   localparam int RESET_CYCLES = 3200;

   logic        clk       = 1'b0;
   logic        rst_n     = 1'b0;
   logic        din       = 1'b0;
   logic        clear_err = 1'b0;
   logic        ready_ctl = 1'b1;
   logic        rnd_mode  = 1'b0;
   logic        rnd_bit   = 1'b1;
   logic        data_ready;
   logic [23:0] data_out;
   logic        data_valid;
   logic        frame_end;
   logic [7:0]  frame_words;
   logic        bit_error;
   logic        overrun;

   int n_tests = 0;
   int n_fail  = 0;

   logic [23:0] exp_q[$];
   int          frame_q[$];

   // Decode model: a run of bits, words completed and whether a gap is owed.
   int          m_bits;
   logic [23:0] m_acc;
   bit          m_dead;
   bit          m_any;
   int          m_words;
   bit          m_err;

   assign data_ready = rnd_mode ? rnd_bit : ready_ctl;

   ws2812b_rx_decoder #(
      .THRESH       (THRESH),
      .MIN_HIGH     (MIN_HIGH),
      .MAX_HIGH     (MAX_HIGH),
      .RESET_CYCLES (RESET_CYCLES)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .din         (din),
      .data_out    (data_out),
      .data_valid  (data_valid),
      .data_ready  (data_ready),
      .frame_end   (frame_end),
      .frame_words (frame_words),
      .bit_error   (bit_error),
      .overrun     (overrun),
      .clear_err   (clear_err)
   );

   always #5 clk = ~clk;

   always begin
      @(posedge clk);
      #2;
      rnd_bit = ($urandom_range(3) != 0);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic m_reset();
      m_bits  = 0;
      m_acc   = '0;
      m_dead  = 1'b1;
      m_any   = 1'b0;
      m_words = 0;
      m_err   = 1'b0;
   endtask

   task automatic m_pulse(input int h, input bit push);
      if (m_dead) return;
      if (h < MIN_HIGH || h >= MAX_HIGH) begin
         m_err   = 1'b1;
         m_dead  = 1'b1;
         m_bits  = 0;
         m_words = 0;
         m_any   = 1'b0;
         return;
      end
      m_any = 1'b1;
      m_acc = {m_acc[22:0], (h >= THRESH)};
      m_bits++;
      if (m_bits == 24) begin
         m_bits = 0;
         if (m_words < 255) m_words++;
         if (push) exp_q.push_back(m_acc);
      end
   endtask

   task automatic m_gap();
      if (m_dead) begin
         m_dead = 1'b0;
      end else if (m_any) begin
         frame_q.push_back(m_words);
         if (m_bits != 0) m_err = 1'b1;
         m_words = 0;
         m_bits  = 0;
         m_any   = 1'b0;
      end
   endtask

   task automatic send_pulse(input int h, input int l, input bit push);
      m_pulse(h, push);
      din = 1'b1;
      tick(h);
      din = 1'b0;
      tick(l);
   endtask

   task automatic send_word(input logic [23:0] w, input int h0, input int h1,
                            input int l0, input int l1, input bit push);
      for (int i = 23; i >= 0; i--) begin
         if (w[i]) send_pulse(h1, l1, push);
         else      send_pulse(h0, l0, push);
      end
   endtask

   task automatic gap();
      din = 1'b0;
      m_gap();
      tick(RESET_CYCLES + 40);
   endtask

   task automatic clear_errors();
      clear_err = 1'b1;
      tick(1);
      clear_err = 1'b0;
      m_err     = 1'b0;
   endtask

   // Scoreboard: every accepted word and every frame end is matched in order.
   always @(negedge clk) begin
      if (rst_n && data_valid && data_ready) begin
         if (exp_q.size() == 0) check("unexpected_valid", data_valid, 1'b0);
         else                   check("word", data_out, exp_q.pop_front());
      end
      if (rst_n && frame_end) begin
         if (frame_q.size() == 0) check("unexpected_frame_end", frame_end, 1'b0);
         else                     check("frame_words", frame_words, frame_q.pop_front());
      end
   end

   initial begin
      logic [23:0] w;
      int          nw;

      m_reset();
      tick(3);
      check("rst_data_out", data_out, 0);
      check("rst_data_valid", data_valid, 0);
      check("rst_frame_end", frame_end, 0);
      check("rst_frame_words", frame_words, 0);
      check("rst_bit_error", bit_error, 0);
      check("rst_overrun", overrun, 0);
      rst_n = 1'b1;
      gap();

      // Single word with nominal timing and the output latency edge by edge.
      w = 24'h12AB3C;
      for (int i = 23; i >= 1; i--) begin
         if (w[i]) send_pulse(51, 29, 1'b1);
         else      send_pulse(26, 54, 1'b1);
      end
      m_pulse(26, 1'b1);
      din = 1'b1;
      tick(26);
      din = 1'b0;
      tick(3);
      check("t1_valid_edge3", data_valid, 0);
      tick(1);
      check("t1_valid_edge4", data_valid, 1);
      check("t1_data_out", data_out, 24'h12AB3C);
      tick(1);
      check("t1_valid_one_cycle", data_valid, 0);
      tick(50);
      gap();
      check("t1_pending", exp_q.size(), 0);

      // Two words in one frame.
      send_word(24'hFF0000, 26, 51, 54, 29, 1'b1);
      send_word(24'h0000FF, 26, 51, 54, 29, 1'b1);
      gap();
      check("t2_frame_words", frame_words, 2);
      check("t2_pending", exp_q.size(), 0);
      check("t2_frames", frame_q.size(), 0);

      // Width boundaries, then a glitch and an overlong pulse.
      send_word(24'hA5C31E, 37, 38, 40, 40, 1'b1);
      send_word(24'h3C96E1, 8, 95, 40, 30, 1'b1);
      check("t3_no_error", bit_error, 0);
      for (int i = 0; i < 5; i++) send_pulse(50, 30, 1'b1);
      send_pulse(7, 40, 1'b1);
      for (int i = 0; i < 6; i++) send_pulse(50, 30, 1'b1);
      check("t3_glitch_err", bit_error, m_err);
      gap();
      clear_errors();
      send_pulse(96, 40, 1'b1);
      check("t3_long_err", bit_error, m_err);
      gap();
      clear_errors();
      send_word(24'h0F1E2D, 20, 60, 45, 25, 1'b1);
      gap();
      check("t3_pending", exp_q.size(), 0);
      check("t3_frames", frame_q.size(), 0);

      // Back-pressure: second word overruns.
      ready_ctl = 1'b0;
      send_word(24'hAAAAAA, 26, 51, 54, 29, 1'b0);
      send_word(24'h555555, 26, 51, 54, 29, 1'b0);
      tick(10);
      check("t4_data_out", data_out, 24'hAAAAAA);
      check("t4_valid_held", data_valid, 1);
      check("t4_overrun", overrun, 1);
      exp_q.push_back(24'hAAAAAA);
      ready_ctl = 1'b1;
      tick(1);
      check("t4_valid_drop", data_valid, 0);
      clear_errors();
      check("t4_overrun_clr", overrun, 0);
      gap();

      // Partial word at the gap.
      for (int i = 0; i < 12; i++) send_pulse(($urandom_range(1) != 0) ? 51 : 26, 40, 1'b1);
      gap();
      check("t5_bit_error", bit_error, m_err);
      check("t5_frame_words", frame_words, 0);
      check("t5_frames", frame_q.size(), 0);
      clear_errors();

      // Randomized frames under random back-pressure.
      rnd_mode = 1'b1;
      for (int f = 0; f < 2; f++) begin
         nw = int'($urandom_range(2, 1));
         for (int k = 0; k < nw; k++) begin
            send_word(24'($urandom),
                      int'($urandom_range(THRESH - 1, MIN_HIGH)),
                      int'($urandom_range(MAX_HIGH - 1, THRESH)),
                      int'($urandom_range(40, 20)),
                      int'($urandom_range(40, 20)), 1'b1);
         end
         gap();
      end
      rnd_mode = 1'b0;
      tick(5);
      check("rnd_pending", exp_q.size(), 0);
      check("rnd_frames", frame_q.size(), 0);
      check("rnd_bit_error", bit_error, 0);
      check("rnd_overrun", overrun, 0);

      // Reset mid-word, interrupted resync, then clean decode.
      for (int i = 0; i < 10; i++) send_pulse(51, 29, 1'b1);
      rst_n = 1'b0;
      tick(3);
      m_reset();
      check("t6_valid", data_valid, 0);
      check("t6_frame_words", frame_words, 0);
      check("t6_data_out", data_out, 0);
      rst_n = 1'b1;
      tick(3000);
      din = 1'b1;
      tick(30);
      din = 1'b0;
      tick(1000);
      for (int i = 0; i < 6; i++) send_pulse(51, 29, 1'b1);
      gap();
      send_word(24'h6B2F90, 26, 51, 54, 29, 1'b1);
      gap();
      check("t6_pending", exp_q.size(), 0);
      check("t6_frames", frame_q.size(), 0);
      check("t6_bit_error", bit_error, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
